// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared constants and feeder state type for the systolic array slice
// Purpose: default array geometry and the feeder FSM state encoding.
//   Both the feeder and the array import this package.
// Ports: none (package).
package systolic_pkg;

  localparam int DEF_ROWS   = 4;
  localparam int DEF_COLS   = 4;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 128;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FEED,
    ST_DRAIN,
    ST_DONE
  } feeder_state_t;

endpackage

// File: rtl/systolic_feeder_if.sv
// rtl/systolic_feeder_if.sv - control and bank/operand bundle between controller, banks and feeder
// Purpose: groups the start/done handshake, the bank read ports and the skewed operand outputs.
// Ports (signals):
//   start, base_addr, k_len          run request from the controller
//   busy, done, array_clr            run status and array accumulator clear
//   rd_en_w/n, rd_addr_w/n           per-bank read enables and packed addresses
//   rd_data_w/n                      bank read data, one cycle after the address
//   west_out, north_out              skewed, zero-padded operands to the array
// Modports: slave = feeder side, master = controller/bank side.
interface systolic_feeder_if
  import systolic_pkg::*;
#(
  parameter int ROWS   = DEF_ROWS,
  parameter int COLS   = DEF_COLS,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) ();

  logic                     start;
  logic [ADDR_W-1:0]        base_addr;
  logic [ADDR_W:0]          k_len;
  logic                     busy;
  logic                     done;
  logic                     array_clr;
  logic [ROWS-1:0]          rd_en_w;
  logic [COLS-1:0]          rd_en_n;
  logic [ROWS*ADDR_W-1:0]   rd_addr_w;
  logic [COLS*ADDR_W-1:0]   rd_addr_n;
  logic [ROWS*DATA_W-1:0]   rd_data_w;
  logic [COLS*DATA_W-1:0]   rd_data_n;
  logic [ROWS*DATA_W-1:0]   west_out;
  logic [COLS*DATA_W-1:0]   north_out;

  modport slave (
    input  start, base_addr, k_len, rd_data_w, rd_data_n,
    output busy, done, array_clr, rd_en_w, rd_en_n, rd_addr_w, rd_addr_n, west_out, north_out
  );

  modport master (
    output start, base_addr, k_len, rd_data_w, rd_data_n,
    input  busy, done, array_clr, rd_en_w, rd_en_n, rd_addr_w, rd_addr_n, west_out, north_out
  );

endinterface

// File: rtl/feeder_lane.sv
// rtl/feeder_lane.sv - one skewed operand lane: window compare, wrapped address, zero-pad output
// Purpose: lane LANE reads element t-LANE while LANE <= t < LANE+k_len, otherwise idles on base.
//   The output register carries the bank word two cycles after its address, or 0 outside the window.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   run             feed phase in progress
//   kill            synchronous flush of the delay/output registers (abort)
//   t               feed cycle index
//   base, k_len     captured run base address and operand count
//   rd_data         bank read data (registered, one cycle after rd_addr)
//   rd_en, rd_addr  bank read port
//   dout            skewed, zero-padded operand
module feeder_lane #(
  parameter int LANE   = 0,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 7,
  parameter int DEPTH  = 128,
  parameter int T_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              kill,
  input  logic [T_W-1:0]    t,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   k_len,
  input  logic [DATA_W-1:0] rd_data,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] dout
);

  localparam int CW = T_W + 1;

  // One extra bit so the borrow of t - LANE tells us t is still before the window.
  logic [CW:0]       diff;
  logic              active;
  logic [ADDR_W:0]   sum;
  logic              act_q;

  assign diff   = {2'b00, t} - (CW+1)'(LANE);
  assign active = run && !diff[CW] && (diff[CW-1:0] < CW'(k_len));

  // base + offset < 2*DEPTH, so a single conditional subtract implements the wrap.
  assign sum     = {1'b0, base} + {1'b0, ADDR_W'(diff[CW-1:0])};
  assign rd_en   = active;
  assign rd_addr = active ? ADDR_W'((sum >= (ADDR_W+1)'(DEPTH)) ? sum - (ADDR_W+1)'(DEPTH) : sum)
                          : base;

  // act_q lines the window flag up with the bank's registered data; dout is the second stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_q <= 1'b0;
      dout  <= '0;
    end else if (kill) begin
      act_q <= 1'b0;
      dout  <= '0;
    end else begin
      act_q <= active;
      dout  <= act_q ? rd_data : '0;
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - start/done sequencer feeding skewed operands into the systolic array
// Purpose: one accepted start sweeps all west/north banks with diagonal skew, waits ROWS+COLS
//   cycles for the array to drain and pulses done.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   abort      (only with FEEDER_ABORT_EN) cancel a run in FEED/DRAIN without a done pulse
//   bus        systolic_feeder_if.slave: start/base_addr/k_len in, busy/done/array_clr out,
//              bank read ports and west_out/north_out operands
// Optional feature macro: FEEDER_ABORT_EN.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int ROWS   = DEF_ROWS,
  parameter int COLS   = DEF_COLS,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic rst,
`ifdef FEEDER_ABORT_EN
  input  logic abort,
`endif
  systolic_feeder_if.slave bus
);

  localparam int MAX_RC = (ROWS > COLS) ? ROWS : COLS;
  // t counts both the feed window and the drain period.
  localparam int T_W    = $clog2(DEPTH + ROWS + COLS + 1);

  feeder_state_t         state;
  logic [T_W-1:0]        t;
  logic [T_W-1:0]        t_last;
  logic [ADDR_W-1:0]     base_q;
  logic [ADDR_W:0]       klen_q;
  logic                  busy_q, done_q, clr_q;
  logic                  k_ok, accept, run, kill;
  logic [ROWS-1:0]       en_w;
  logic [COLS-1:0]       en_n;
  logic [ROWS*ADDR_W-1:0] addr_w;
  logic [COLS*ADDR_W-1:0] addr_n;
  logic [ROWS*DATA_W-1:0] west_d;
  logic [COLS*DATA_W-1:0] north_d;

  assign k_ok   = (bus.k_len != '0) && (bus.k_len <= (ADDR_W+1)'(DEPTH));
  assign accept = ((state == ST_IDLE) || (state == ST_DONE)) && bus.start && k_ok;
  assign run    = (state == ST_FEED);
  // Last feed cycle is F-1 = k_len + MAX_RC - 2.
  assign t_last = T_W'(klen_q) + T_W'(MAX_RC) - T_W'(2);

`ifdef FEEDER_ABORT_EN
  assign kill = abort && ((state == ST_FEED) || (state == ST_DRAIN));
`else
  assign kill = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      t      <= '0;
      base_q <= '0;
      klen_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      clr_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      clr_q  <= 1'b0;
      if (kill) begin
        state  <= ST_IDLE;
        t      <= '0;
        busy_q <= 1'b0;
      end else begin
        case (state)
          ST_IDLE, ST_DONE: begin
            if (accept) begin
              state  <= ST_FEED;
              t      <= '0;
              base_q <= bus.base_addr;
              klen_q <= bus.k_len;
              busy_q <= 1'b1;
              clr_q  <= 1'b1;
            end else begin
              state  <= ST_IDLE;
            end
          end
          ST_FEED: begin
            if (t == t_last) begin
              state <= ST_DRAIN;
              t     <= '0;
            end else begin
              t <= t + T_W'(1);
            end
          end
          ST_DRAIN: begin
            if (t == T_W'(ROWS + COLS - 1)) begin
              state  <= ST_DONE;
              t      <= '0;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              t <= t + T_W'(1);
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  for (genvar i = 0; i < ROWS; i++) begin : g_west
    feeder_lane #(
      .LANE(i), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .T_W(T_W)
    ) u_lane (
      .clk(clk), .rst(rst), .run(run), .kill(kill), .t(t),
      .base(base_q), .k_len(klen_q),
      .rd_data(bus.rd_data_w[i*DATA_W +: DATA_W]),
      .rd_en(en_w[i]),
      .rd_addr(addr_w[i*ADDR_W +: ADDR_W]),
      .dout(west_d[i*DATA_W +: DATA_W])
    );
  end

  for (genvar i = 0; i < COLS; i++) begin : g_north
    feeder_lane #(
      .LANE(i), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .T_W(T_W)
    ) u_lane (
      .clk(clk), .rst(rst), .run(run), .kill(kill), .t(t),
      .base(base_q), .k_len(klen_q),
      .rd_data(bus.rd_data_n[i*DATA_W +: DATA_W]),
      .rd_en(en_n[i]),
      .rd_addr(addr_n[i*ADDR_W +: ADDR_W]),
      .dout(north_d[i*DATA_W +: DATA_W])
    );
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.array_clr = clr_q;
  assign bus.rd_en_w   = en_w;
  assign bus.rd_en_n   = en_n;
  assign bus.rd_addr_w = addr_w;
  assign bus.rd_addr_n = addr_n;
  assign bus.west_out  = west_d;
  assign bus.north_out = north_d;

endmodule
